// File: rtl/wb_counter_periph_if.sv
// rtl/wb_counter_periph_if.sv - Wishbone classic slave bus bundle for wb_counter_periph
//
// Purpose: groups the Wishbone slave signals of the counter peripheral.
// Signals (named from the slave's point of view):
//   wbs_cyc_i, wbs_stb_i, wbs_we_i   cycle, strobe, write enable
//   wbs_sel_i[3:0]                   byte lane enables for writes
//   wbs_adr_i[31:0], wbs_dat_i[31:0] byte address, write data
//   wbs_ack_o                        registered acknowledge
//   wbs_dat_o[31:0]                  read data, valid while wbs_ack_o=1
interface wb_counter_periph_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_counter_periph.sv
// rtl/wb_counter_periph.sv - Wishbone slave 32-bit up/down counter with reload, compare and irq
//
// Purpose: free-running up/down counter with auto-reload, sticky compare-match and
//   wrap flags (write-1-to-clear) and a level interrupt, in a 256-byte register window.
// Ports:
//   wb_clk_i  in   single clock, rising edge
//   wb_rst_i  in   asynchronous active-high reset
//   wb        slave modport of wb_counter_periph_if (Wishbone classic)
//   irq_o     out  level interrupt = IRQ_EN & (MATCH | WRAP)
// Registers (offset): 0x00 CTRL, 0x04 COUNT, 0x08 RELOAD, 0x0C COMPARE,
//   0x10 STATUS (W1C), 0x14 ID; other offsets read 0 and ignore writes.
module wb_counter_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIDTH     = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_counter_periph_if.slave   wb,
  output logic                 irq_o
);

  localparam logic [31:0] ID_VALUE = 32'h5743_4E54;

  logic [3:0]       ctrl_q;     // [0]EN [1]DOWN [2]IRQ_EN [3]AUTO_RELOAD
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] compare_q;
  logic             match_q;
  logic             wrap_q;
  logic             ack_q;
  logic [31:0]      dat_q;

  logic             acc;
  logic             wr;
  logic [7:0]       off;
  logic [31:0]      rd_data;
  logic [WIDTH-1:0] count_d;
  logic             at_wrap;
  logic             wr_count;
  logic             match_set;
  logic             wrap_set;
  logic [1:0]       status_clr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    // An access is only taken while ack is low, so a held strobe acks every other cycle.
    acc = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    wr  = acc & wb.wbs_we_i;
    off = wb.wbs_adr_i[7:0];

    rd_data = '0;
    case (off)
      8'h00:   rd_data = {28'd0, ctrl_q};
      8'h04:   rd_data = count_q;
      8'h08:   rd_data = reload_q;
      8'h0C:   rd_data = compare_q;
      8'h10:   rd_data = {30'd0, wrap_q, match_q};
      8'h14:   rd_data = ID_VALUE;
      default: rd_data = '0;
    endcase

    wr_count = wr & (off == 8'h04);
    at_wrap  = ctrl_q[1] ? (count_q == '0) : (count_q == {WIDTH{1'b1}});

    // A software write to COUNT wins over the step on the same edge.
    count_d  = count_q;
    wrap_set = 1'b0;
    if (wr_count) begin
      count_d = merge_bytes(count_q, wb.wbs_dat_i, wb.wbs_sel_i);
    end else if (ctrl_q[0]) begin
      wrap_set = at_wrap;
      if (at_wrap && ctrl_q[3]) begin
        count_d = reload_q;
      end else if (ctrl_q[1]) begin
        count_d = count_q - 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    match_set  = (wr_count | ctrl_q[0]) & (count_d == compare_q);
    status_clr = (wr && off == 8'h10 && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[1:0] : 2'b00;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      reload_q  <= '0;
      compare_q <= {WIDTH{1'b1}};
      match_q   <= 1'b0;
      wrap_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      ack_q   <= acc;
      count_q <= count_d;
      if (acc && !wb.wbs_we_i) begin
        dat_q <= rd_data;
      end
      if (wr && off == 8'h00 && wb.wbs_sel_i[0]) begin
        ctrl_q <= wb.wbs_dat_i[3:0];
      end
      if (wr && off == 8'h08) begin
        reload_q <= merge_bytes(reload_q, wb.wbs_dat_i, wb.wbs_sel_i);
      end
      if (wr && off == 8'h0C) begin
        compare_q <= merge_bytes(compare_q, wb.wbs_dat_i, wb.wbs_sel_i);
      end
      // Hardware set beats the write-1-to-clear on the same edge.
      match_q <= match_set | (match_q & ~status_clr[0]);
      wrap_q  <= wrap_set  | (wrap_q  & ~status_clr[1]);
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign irq_o        = ctrl_q[2] & (match_q | wrap_q);

endmodule

// File: tb/tb_wb_counter_periph.sv
// tb/tb_wb_counter_periph.sv - directed scoreboard testbench for wb_counter_periph
module tb_wb_counter_periph;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_COUNT = BASE + 32'h04;
  localparam logic [31:0] A_RELOAD = BASE + 32'h08;
  localparam logic [31:0] A_COMPARE = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;
  localparam logic [31:0] A_ID = BASE + 32'h14;

  logic clk;
  logic rst;
  logic irq;
  int   checks;
  int   failures;
  logic [31:0] sb_q[$];

  wb_counter_periph_if bus ();

  wb_counter_periph #(.BASE_ADDR(BASE), .WIDTH(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus.slave),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int budget,
                        output logic [31:0] rdat, output bit acked, output int lat);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    acked = 1'b0;
    lat   = 0;
    rdat  = '0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        lat   = i;
        rdat  = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] d;
    bit a;
    int l;
    access(1'b1, adr, dat, sel, 8, d, a, l);
    chk({tag, "_ack"}, {31'd0, a}, 32'd1);
  endtask

  task automatic rd_val(input string tag, input logic [31:0] adr, output logic [31:0] v);
    bit a;
    int l;
    access(1'b0, adr, '0, 4'hF, 8, v, a, l);
    chk({tag, "_ack"}, {31'd0, a}, 32'd1);
  endtask

  // Expected value goes into the scoreboard at drive time; it is popped when the ack arrives.
  task automatic rd_exp(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    logic [31:0] e;
    bit a;
    int l;
    sb_q.push_back(exp);
    access(1'b0, adr, '0, 4'hF, 8, d, a, l);
    e = sb_q.pop_front();
    if (!a) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else    chk(tag, d, e);
  endtask

  initial begin
    logic [31:0] r1, r2, r3, r4, d;
    bit a;
    int l;
    int acks;
    checks   = 0;
    failures = 0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // ID read, one-cycle latency
    sb_q.push_back(32'h5743_4E54);
    access(1'b0, A_ID, '0, 4'hF, 8, d, a, l);
    chk("id_latency", l, 1);
    chk("id_val", d, sb_q.pop_front());
    rd_exp("rst_ctrl", A_CTRL, 32'd0);
    rd_exp("rst_compare", A_COMPARE, 32'hFFFF_FFFF);
    rd_exp("rst_count", A_COUNT, 32'd0);
    rd_exp("rst_status", A_STATUS, 32'd0);
    wr("id_wr", A_ID, 32'h1234_5678, 4'hF);
    rd_exp("id_ro", A_ID, 32'h5743_4E54);
    rd_exp("unmapped_rd", BASE + 32'h20, 32'd0);

    // Free-running up count, then hold
    wr("cnt5", A_COUNT, 32'd5, 4'hF);
    wr("en_up", A_CTRL, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    rd_val("up_r1", A_COUNT, r1);
    rd_val("up_r2", A_COUNT, r2);
    chk("up_gt5", {31'd0, r1 > 32'd5}, 32'd1);
    chk("up_mono", {31'd0, r2 > r1}, 32'd1);
    wr("stop1", A_CTRL, 32'h0, 4'hF);
    rd_val("hold_r3", A_COUNT, r3);
    repeat (4) @(negedge clk);
    rd_val("hold_r4", A_COUNT, r4);
    chk("hold_eq", r4, r3);
    chk("hold_ge", {31'd0, r3 >= r2}, 32'd1);

    // Up wrap with auto reload
    wr("cnt_fe", A_COUNT, 32'hFFFF_FFFE, 4'hF);
    wr("rl10", A_RELOAD, 32'd10, 4'hF);
    wr("en_ar", A_CTRL, 32'h9, 4'hF);
    repeat (3) @(negedge clk);
    wr("stop2", A_CTRL, 32'h0, 4'hF);
    rd_val("wrap_cnt", A_COUNT, r1);
    chk("wrap_reload_range", {31'd0, (r1 >= 32'd10) && (r1 <= 32'd20)}, 32'd1);
    rd_exp("wrap_status", A_STATUS, 32'h3);
    chk("wrap_irq_off", {31'd0, irq}, 32'd0);
    wr("w1c_wrap", A_STATUS, 32'h2, 4'hF);
    rd_exp("w1c_wrap_only", A_STATUS, 32'h1);
    wr("w1c_all", A_STATUS, 32'h3, 4'hF);

    // Down count through zero, natural wrap
    wr("cnt3", A_COUNT, 32'd3, 4'hF);
    wr("en_dn", A_CTRL, 32'h3, 4'hF);
    repeat (6) @(negedge clk);
    wr("stop3", A_CTRL, 32'h0, 4'hF);
    rd_val("dn_cnt", A_COUNT, r1);
    chk("dn_range", {31'd0, r1 >= 32'hFFFF_FFF0}, 32'd1);
    rd_exp("dn_status", A_STATUS, 32'h3);
    wr("w1c_dn", A_STATUS, 32'h3, 4'hF);

    // Compare match and interrupt
    wr("cmp100", A_COMPARE, 32'd100, 4'hF);
    wr("cnt90", A_COUNT, 32'd90, 4'hF);
    wr("en_irq", A_CTRL, 32'h5, 4'hF);
    chk("irq_pre", {31'd0, irq}, 32'd0);
    l = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (irq) begin
        l = k;
        break;
      end
    end
    chk("match_cycles", l, 10);
    wr("stop4", A_CTRL, 32'h4, 4'hF);
    rd_exp("match_status", A_STATUS, 32'h1);
    chk("irq_held", {31'd0, irq}, 32'd1);
    wr("w1c_match", A_STATUS, 32'h3, 4'hF);
    chk("irq_drop", {31'd0, irq}, 32'd0);

    // Byte-lane write and out-of-window access
    wr("rl_sel", A_RELOAD, 32'hAABB_CCDD, 4'b0001);
    rd_exp("rl_sel_rd", A_RELOAD, 32'h0000_00DD);
    access(1'b0, BASE + 32'h100, '0, 4'hF, 4, d, a, l);
    chk("miss_noack", {31'd0, a}, 32'd0);

    // Held strobe acks every other cycle
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = A_ID;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wbs_ack_o) acks++;
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    chk("b2b_acks", acks, 2);

    // Reset during an access drops it
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = A_COMPARE;
    bus.wbs_dat_i = 32'h0000_0055;
    bus.wbs_sel_i = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    rst = 1'b0;
    rd_exp("rst_mid_compare", A_COMPARE, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
